mem_burst_reader: RTL

Initiator-side read engine for the windowed `mem` block: the read-side counterpart of the write traffic the memory accepts.
- Accepts a burst command (start address, length) on a valid/ready port.
- Issues synchronous reads (`ren`/`raddr`, SYNCREAD=1 style) into a `mem` instance mapped at OFFSET..OFFSET+DEPTH-1.
- Streams the returned words out on a valid/ready port, with last-beat marking and backpressure.
- Sits between a test/emulation controller and a `mem` instance.

---
 rtl/mem_reader_pkg.sv | 19 +
 rtl/mem_reader_fifo.sv | 50 +++++
 rtl/mem_burst_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_reader_pkg.sv
// Shared types and helpers for the mem window reader/writer engines.
package mem_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // True when [addr, addr+len] lies inside [offset, offset+depth-1].
  // The arguments are widened to 32 bits, so the sum cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] len,
                                     input logic [31:0] offset,
                                     input logic [31:0] depth);
    return (addr >= offset) && (addr + len + 32'd1 <= offset + depth);
  endfunction

endpackage

// File: rtl/mem_reader_fifo.sv
// Two-entry FIFO of {last, data}. Its occupancy count feeds the read-credit logic.
module mem_reader_fifo
  import mem_reader_pkg::*;
#(
  parameter int WIDTH = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_last,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic [1:0]       count
);

  logic [WIDTH:0] slots [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic           push_fire;
  logic           pop_fire;

  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  assign push_fire = push && ((count != 2'd2) || pop);
  assign pop_fire  = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) slots[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_fire) begin
        slots[wr_ptr] <= {push_last, push_data};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_fire) rd_ptr <= ~rd_ptr;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign {last, data} = slots[rd_ptr];

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine for the windowed mem block: command in, synchronous reads out, beat stream back.
// Optional counters stat_beats/stat_errs are enabled by defining MEM_BURST_READER_STATS_EN.
module mem_burst_reader
  import mem_reader_pkg::*;
#(
  parameter int WIDTH      = 80,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 32,
  parameter int OFFSET     = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
`ifdef MEM_BURST_READER_STATS_EN
  output logic [31:0]           stat_beats,
  output logic [15:0]           stat_errs,
`endif
  output state_e                fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and an offered command is held until it is accepted.

  state_e                state;
  state_e                state_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  err_q;
  logic                  accept;
  logic                  window_ok;
  logic                  issue;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [1:0]            eff_occ;
  logic                  fifo_last;

  assign accept    = cmd_valid && cmd_ready;
  assign window_ok = in_window(32'(cmd_addr), 32'(cmd_len), 32'(OFFSET), 32'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A word leaving this cycle frees its slot in time for a read issued now.
  assign eff_occ   = fifo_count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && window_ok) state_n = ST_RUN;
      end
      ST_RUN: begin
        issue = ({1'b0, eff_occ} + {2'b00, inflight}) < 3'd2;
        if (issue && (remaining == '0)) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q         <= accept && !window_ok;
      inflight      <= issue;
      inflight_last <= issue && (remaining == '0);
      if (accept && window_ok) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  mem_reader_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (mem_rdata),
    .pop       (pop),
    .data      (out_data),
    .last      (fifo_last),
    .count     (fifo_count)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign cmd_err   = err_q;
  assign mem_ren   = issue;
  assign mem_raddr = cur_addr;
  assign out_valid = (fifo_count != 2'd0);
  assign out_last  = out_valid && fifo_last;
  assign fsm_state = state;

`ifdef MEM_BURST_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_errs  <= '0;
    end else begin
      if (pop && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
      if (err_q && (stat_errs != '1)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
